// File: rtl/muldiv_seq_pkg.sv
// Shared RV32M definitions: opcode/funct constants and sequencer state encoding.
package muldiv_seq_pkg;

  localparam logic [6:0] OPC_OP        = 7'b0110011;
  localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

  localparam logic [2:0] FNC_MUL    = 3'b000;
  localparam logic [2:0] FNC_MULH   = 3'b001;
  localparam logic [2:0] FNC_MULHSU = 3'b010;
  localparam logic [2:0] FNC_MULHU  = 3'b011;
  localparam logic [2:0] FNC_DIV    = 3'b100;
  localparam logic [2:0] FNC_DIVU   = 3'b101;
  localparam logic [2:0] FNC_REM    = 3'b110;
  localparam logic [2:0] FNC_REMU   = 3'b111;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_PREP = 3'd1,
    S_RUN  = 3'd2,
    S_FIX  = 3'd3,
    S_DONE = 3'd4
  } state_t;

endpackage

// File: rtl/muldiv_seq_if.sv
// Execute-stage <-> M-extension sequencer handshake.
interface muldiv_seq_if #(
    parameter int XLEN = 32
);
    logic            start;
    logic [2:0]      funct3;
    logic [XLEN-1:0] rs1;
    logic [XLEN-1:0] rs2;
    logic            kill;
    logic            stall;
    logic            busy;
    logic            done;
    logic [XLEN-1:0] result;

    modport master (output start, funct3, rs1, rs2, kill,
                    input  stall, busy, done, result);
    modport slave  (input  start, funct3, rs1, rs2, kill,
                    output stall, busy, done, result);
endinterface

// File: rtl/muldiv_datapath.sv
// Operand/accumulator registers, shift-add multiply and restoring divide steps, sign fix.
// MULDIV_FAST_MUL_EN loads a single signed DSP product into the accumulator on accept.
module muldiv_datapath
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld,
    input  logic            ld_special,
    input  logic            prep,
    input  logic            step,
    input  logic            fix,
    input  logic [2:0]      funct3,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            is_special,
    output logic            cnt_zero,
    output logic [XLEN-1:0] result
);
    logic [XLEN-1:0]   a_q, b_q;
    logic [2*XLEN-1:0] acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              neg_q;
    logic [2:0]        fnc_q;

    function automatic logic [XLEN-1:0] neg_w(input logic n, input logic [XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    function automatic logic [2*XLEN-1:0] neg_d(input logic n, input logic [2*XLEN-1:0] v);
        return n ? (~v + 1'b1) : v;
    endfunction

    // Divide-by-zero and signed overflow results come straight from the operands.
    function automatic logic [XLEN-1:0] special_res(input logic [2:0] f, input logic bzero,
                                                    input logic [XLEN-1:0] a);
        if (bzero) return f[1] ? a : '1;
        return f[1] ? '0 : a;
    endfunction

    logic div_zero, sovf;
    assign div_zero   = funct3[2] && (rs2 == '0);
    assign sovf       = (funct3 == FNC_DIV || funct3 == FNC_REM) &&
                        (rs1 == {1'b1, {(XLEN-1){1'b0}}}) && (rs2 == '1);
    assign is_special = div_zero | sovf;
    assign cnt_zero   = (cnt_q == '0);

    logic a_sgn, b_sgn, a_neg, b_neg, neg_nxt;
    assign a_sgn   = fnc_q inside {FNC_MULH, FNC_MULHSU, FNC_DIV, FNC_REM};
    assign b_sgn   = fnc_q inside {FNC_MULH, FNC_DIV, FNC_REM};
    assign a_neg   = a_sgn & a_q[XLEN-1];
    assign b_neg   = b_sgn & b_q[XLEN-1];
    assign neg_nxt = (fnc_q[2] && fnc_q[1]) ? a_neg : (a_neg ^ b_neg);

    logic [2*XLEN-1:0] mul_nxt, div_nxt;
    logic [XLEN:0]     rem_sh, diff;
    logic              ge;
    assign mul_nxt = {acc_q[2*XLEN-2:0], 1'b0} +
                     ({(2*XLEN){a_q[cnt_q]}} & {{XLEN{1'b0}}, b_q});
    assign rem_sh  = {acc_q[2*XLEN-1:XLEN], a_q[cnt_q]};
    assign diff    = rem_sh - {1'b0, b_q};
    assign ge      = (rem_sh >= {1'b0, b_q});
    assign div_nxt = {(ge ? diff[XLEN-1:0] : rem_sh[XLEN-1:0]), acc_q[XLEN-2:0], ge};

    logic [2*XLEN-1:0] mul_full;
    logic [XLEN-1:0]   fix_res;
    assign mul_full = neg_d(neg_q, acc_q);
    always_comb begin
        fix_res = '0;
        case (fnc_q)
            FNC_MUL:                        fix_res = mul_full[XLEN-1:0];
            FNC_MULH, FNC_MULHSU, FNC_MULHU: fix_res = mul_full[2*XLEN-1:XLEN];
            FNC_DIV, FNC_DIVU:              fix_res = neg_w(neg_q, acc_q[XLEN-1:0]);
            default:                        fix_res = neg_w(neg_q, acc_q[2*XLEN-1:XLEN]);
        endcase
    end

`ifdef MULDIV_FAST_MUL_EN
    logic signed [2*XLEN-1:0] fa, fb, fprod;
    logic                     fa_s, fb_s;
    assign fa_s  = funct3 inside {FNC_MULH, FNC_MULHSU};
    assign fb_s  = (funct3 == FNC_MULH);
    assign fa    = {{XLEN{fa_s & rs1[XLEN-1]}}, rs1};
    assign fb    = {{XLEN{fb_s & rs2[XLEN-1]}}, rs2};
    assign fprod = fa * fb;
`endif

    always_ff @(posedge clk) begin
        if (ld) begin
            a_q   <= rs1;
            b_q   <= rs2;
            fnc_q <= funct3;
            neg_q <= 1'b0;
`ifdef MULDIV_FAST_MUL_EN
            acc_q <= fprod;
`endif
        end else if (prep) begin
            a_q   <= neg_w(a_neg, a_q);
            b_q   <= neg_w(b_neg, b_q);
            neg_q <= neg_nxt;
            acc_q <= '0;
        end else if (step) begin
            acc_q <= fnc_q[2] ? div_nxt : mul_nxt;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q  <= '0;
            result <= '0;
        end else begin
            if (prep)      cnt_q <= CNT_W'(XLEN-1);
            else if (step) cnt_q <= cnt_q - 1'b1;
            if (ld_special) result <= special_res(funct3, div_zero, rs1);
            else if (fix)   result <= fix_res;
        end
    end
endmodule

// File: rtl/muldiv_seq.sv
// RV32M multi-cycle sequencer: FSM, pipeline stall and done pulse around muldiv_datapath.
// MULDIV_FAST_MUL_EN sends multiplies IDLE -> FIX -> DONE using a single-cycle product.
module muldiv_seq
    import muldiv_seq_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 5
) (
    input  logic        clk,
    input  logic        rst,
    muldiv_seq_if.slave bus
);
    state_t state_q;
    logic   done_q;
    logic   is_special, cnt_zero;
    logic   ld, ld_special, prep, step, fix;

    assign ld         = (state_q == S_IDLE) & bus.start & ~bus.kill;
    assign ld_special = ld & is_special;
    assign prep       = (state_q == S_PREP) & ~bus.kill;
    assign step       = (state_q == S_RUN)  & ~bus.kill;
    assign fix        = (state_q == S_FIX)  & ~bus.kill;

    assign bus.stall = ~bus.kill & (((state_q == S_IDLE) & bus.start) |
                                    (state_q inside {S_PREP, S_RUN, S_FIX}));
    assign bus.busy  = (state_q != S_IDLE);
    assign bus.done  = done_q & ~bus.kill;

    muldiv_datapath #(.XLEN(XLEN), .CNT_W(CNT_W)) u_dp (
        .clk        (clk),
        .rst        (rst),
        .ld         (ld),
        .ld_special (ld_special),
        .prep       (prep),
        .step       (step),
        .fix        (fix),
        .funct3     (bus.funct3),
        .rs1        (bus.rs1),
        .rs2        (bus.rs2),
        .is_special (is_special),
        .cnt_zero   (cnt_zero),
        .result     (bus.result)
    );

    // start is not looked at in DONE, so a held instruction cannot re-launch.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            done_q  <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (bus.kill) begin
                state_q <= S_IDLE;
            end else begin
                case (state_q)
                    S_IDLE: if (bus.start) begin
                        if (is_special) begin
                            state_q <= S_DONE;
                            done_q  <= 1'b1;
                        end
`ifdef MULDIV_FAST_MUL_EN
                        else if (!bus.funct3[2]) state_q <= S_FIX;
`endif
                        else state_q <= S_PREP;
                    end
                    S_PREP: state_q <= S_RUN;
                    S_RUN:  if (cnt_zero) state_q <= S_FIX;
                    S_FIX: begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                    default: state_q <= S_IDLE;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: directed RV32M corner cases, random ops, kill and reset.
module tb_muldiv_seq;
    import muldiv_seq_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    muldiv_seq_if #(.XLEN(32)) bus_if ();
    muldiv_seq #(.XLEN(32), .CNT_W(5)) dut (.clk(clk), .rst(rst), .bus(bus_if));

    typedef struct { logic [31:0] res; int lat; } exp_t;
    exp_t        sb_q[$];
    int          total = 0;
    int          bad   = 0;
    logic [31:0] last_res = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got=%h want=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint      sa = longint'($signed(a));
        longint      sb = longint'($signed(b));
        longint      ub = longint'({32'b0, b});
        logic [63:0] p;
        case (f)
            FNC_MUL:    begin p = sa * sb; return p[31:0];  end
            FNC_MULH:   begin p = sa * sb; return p[63:32]; end
            FNC_MULHSU: begin p = sa * ub; return p[63:32]; end
            FNC_MULHU:  begin p = {32'b0, a} * {32'b0, b}; return p[63:32]; end
            FNC_DIV:    begin
                if (b == 0) return 32'hFFFFFFFF;
                p = sa / sb; return p[31:0];
            end
            FNC_DIVU:   return (b == 0) ? 32'hFFFFFFFF : a / b;
            FNC_REM:    begin
                if (b == 0) return a;
                p = sa % sb; return p[31:0];
            end
            default:    return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int exp_lat(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        if (f[2] && (b == 0 || (!f[0] && a == 32'h80000000 && b == 32'hFFFFFFFF))) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!f[2]) return 2;
`endif
        return 35;
    endfunction

    // Drive one op, hold start until done (as a stalled pipeline would), then drop it.
    task automatic do_op(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] exp, input string tag);
        exp_t e;
        int   n = 0, stall_cnt = 0;
        bit   got = 0;
        sb_q.push_back('{res: exp, lat: exp_lat(f, a, b)});
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.funct3 = f; bus_if.rs1 = a; bus_if.rs2 = b;
        while (!got && n < 100) begin
            @(negedge clk);
            if (bus_if.stall) stall_cnt++;
            if (bus_if.done) begin
                got = 1;
                e = sb_q.pop_front();
                chk({tag, " res"}, bus_if.result, e.res);
                chk({tag, " lat"}, n, e.lat);
                chk({tag, " stall"}, stall_cnt, e.lat);
                last_res = e.res;
            end else begin
                @(posedge clk); #1;
                n++;
            end
        end
        chk({tag, " done"}, 32'(got), 1);
        if (!got) void'(sb_q.pop_front());
        @(posedge clk); #1;
        bus_if.start = 1'b0;
        @(negedge clk);
        chk({tag, " norestart"}, {30'b0, bus_if.busy, bus_if.done}, 0);
    endtask

    initial begin
        bus_if.start = 1'b0; bus_if.kill = 1'b0; bus_if.funct3 = '0;
        bus_if.rs1 = '0; bus_if.rs2 = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst outs", {29'b0, bus_if.stall, bus_if.busy, bus_if.done}, 0);
        chk("rst result", bus_if.result, 0);
        @(posedge clk); #1 rst = 1'b0;

        do_op(FNC_DIV,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFA, "div");
        do_op(FNC_REM,    32'hFFFFFFEC, 32'd3,        32'hFFFFFFFE, "rem");
        do_op(FNC_DIVU,   32'd7,        32'd0,        32'hFFFFFFFF, "divu0");
        do_op(FNC_REMU,   32'd7,        32'd0,        32'd7,        "remu0");
        do_op(FNC_DIV,    32'h80000000, 32'hFFFFFFFF, 32'h80000000, "divovf");
        do_op(FNC_REM,    32'h80000000, 32'hFFFFFFFF, 32'd0,        "removf");
        do_op(FNC_MULH,   32'h80000000, 32'h80000000, 32'h40000000, "mulh");
        do_op(FNC_MULHU,  32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, "mulhu");
        do_op(FNC_MULHSU, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, "mulhsu");
        do_op(FNC_MUL,    32'd6,        32'd7,        32'd42,       "mul");
        do_op(FNC_MUL,    32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1,        "mulneg");
        do_op(FNC_DIV,    32'd7,        32'd0,        32'hFFFFFFFF, "div0");
        do_op(FNC_REM,    32'h80000000, 32'd0,        32'h80000000, "rem0");
        do_op(FNC_DIVU,   32'hFFFFFFFF, 32'd10,       32'h19999999, "divu");

        // Kill ten cycles into a divide: no done, result untouched.
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.funct3 = FNC_DIV; bus_if.rs1 = 32'd100; bus_if.rs2 = 32'd7;
        repeat (10) @(posedge clk);
        #1 bus_if.start = 1'b0; bus_if.kill = 1'b1;
        @(negedge clk);
        chk("kill stall", 32'(bus_if.stall), 0);
        chk("kill done", 32'(bus_if.done), 0);
        @(posedge clk); #1 bus_if.kill = 1'b0;
        @(negedge clk);
        chk("kill idle", {30'b0, bus_if.busy, bus_if.done}, 0);
        chk("kill result", bus_if.result, last_res);
        do_op(FNC_DIV, 32'd100, 32'd7, 32'd14, "afterkill");

        // Reset five cycles into a multiply.
        @(posedge clk); #1;
        bus_if.start = 1'b1; bus_if.funct3 = FNC_MULHU; bus_if.rs1 = 32'h12345678; bus_if.rs2 = 32'h9ABCDEF0;
        repeat (5) @(posedge clk);
        #1 rst = 1'b1; bus_if.start = 1'b0;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        chk("midrst outs", {29'b0, bus_if.stall, bus_if.busy, bus_if.done}, 0);
        chk("midrst result", bus_if.result, 0);

        for (int i = 0; i < 12; i++) begin
            logic [2:0]  f;
            logic [31:0] a, b;
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            case ($urandom_range(0, 5))
                0:       b = 32'd0;
                1:       b = 32'($urandom_range(1, 15));
                2:       b = 32'hFFFFFFFF;
                default: b = $urandom;
            endcase
            do_op(f, a, b, model(f, a, b), $sformatf("rnd%0d", i));
        end

        chk("sb empty", sb_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/muldiv_seq.md
Name: muldiv_seq

Overview:
- Multi-cycle sequencer for the RV32M extension, attached to the execute stage of the 3-stage core.
- Accepts a MUL/DIV/REM op together with its forwarded operands, and stalls the pipeline (fetch/decode/execute hold, writeback bubbles) until the result is ready.
- Runs an iterative shift-add multiplier and a restoring divider over shared registers.
- Drives the result into the writeback mux on a one-cycle done pulse.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 5, iteration counter width (log2 XLEN).

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-high reset
- start  in  1  execute_valid and execute opcode is OP with funct7=0000001
- funct3  in  3  M-op select: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
- rs1  in  XLEN  forwarded operand 1
- rs2  in  XLEN  forwarded operand 2
- kill  in  1  flush of the execute instruction (branch redirect or trap)
- stall  out  1  freeze PC/decode/execute registers
- busy  out  1  FSM not IDLE
- done  out  1  result valid this cycle
- result  out  XLEN  M-op result, held until the next accepted start

Behaviour:
- Reset values: stall=0, busy=0, done=0, result=0, state=IDLE, counter=0.
  - rst has priority over every input.
- FSM states: IDLE, PREP, RUN, FIX, DONE.
- IDLE:
  - start=1 latches funct3 and operands, and asserts stall combinationally in the same cycle (T).
  - Next state: PREP, or DONE via the special-case fast path.
- PREP (T+1):
  - Take magnitudes of signed operands.
  - Record result sign: product sign, quotient sign (rs1^rs2), remainder sign (rs1).
  - Clear the 64-bit accumulator; counter=XLEN-1.
- RUN (T+2..T+33), exactly XLEN iterations:
  - Multiply: shift-add of the magnitude product into the 64-bit accumulator.
  - Divide: restoring step producing one quotient bit, with the partial remainder kept in the upper half.
  - Counter decrements; exit to FIX when counter=0.
- FIX (T+34):
  - Conditional two's-complement negation.
  - Select low product (MUL), high product (MULH*), quotient, or remainder into result.
- DONE (T+35):
  - done=1, stall=0; the pipeline advances this cycle.
  - start is ignored in DONE, so the same held instruction cannot restart. Always returns to IDLE.
- Normal-case timing: stall high T..T+34 (35 cycles); done at T+35.
- Special cases, detected in IDLE, go straight to DONE: stall only at T, done at T+1.
  - Divide by zero: DIV/DIVU result=0xFFFFFFFF; REM/REMU result=rs1.
  - Signed overflow (rs1=0x80000000, rs2=0xFFFFFFFF): DIV result=0x80000000; REM result=0.
- MULHSU: rs1 treated as signed, rs2 as unsigned; sign = rs1[31].
- kill in any state: next state IDLE.
  - stall is forced 0 combinationally in that cycle; done is not asserted and result keeps its previous value.
  - kill together with start in IDLE: the op is not accepted.
- stall = (state==IDLE & start & ~kill) | (state in PREP, RUN, FIX).
- busy = state != IDLE.
- All arithmetic is unsigned on magnitudes. The accumulator is 2*XLEN bits and the divider subtractor is XLEN+1 bits; no overflow is possible.

Optional Feature:
- Macro: MULDIV_FAST_MUL_EN.
- Defined:
  - Multiplies use a single registered (XLEN+1)x(XLEN+1) signed DSP product, with operands sign- or zero-extended per funct3.
  - Path: IDLE -> FIX -> DONE. stall high at T and T+1; done at T+2.
  - Divides are unchanged.
- Undefined: multiplies use the iterative path, 36-cycle total as above.

Decomposition:
- Shared package/header holds:
  - M-extension funct3 constants: FNC_MUL..FNC_REMU, alongside the existing FNC_/OPC_ defines.
  - The funct7 value 0000001.
  - FSM state encoding.
- Natural sub-module muldiv_datapath:
  - Operand/accumulator/counter registers, add/subtract step, sign fix.
  - Driven by FSM control strobes from muldiv_seq, which keeps the FSM and stall logic.

Test Plan:
- DIV rs1=-20 (0xFFFFFFEC), rs2=3 -> stall high 35 cycles; done at T+35 with result=0xFFFFFFFA (-6). REM same operands -> 0xFFFFFFFE (-2).
- DIVU rs1=7, rs2=0 -> done at T+1, result=0xFFFFFFFF. REMU same operands -> result=7.
- DIV rs1=0x80000000, rs2=0xFFFFFFFF -> done at T+1, result=0x80000000. REM same operands -> result=0.
- MULH rs1=0x80000000, rs2=0x80000000 -> result=0x40000000. MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE. MULHSU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFF.
- Mid-RUN kill at T+10 -> stall=0 that cycle, no done; a new start at T+12 completes normally. rst at T+5 -> all outputs 0 next cycle.
- start held high through DONE (pipeline holding the instruction) -> exactly one done pulse, no restart. With MULDIV_FAST_MUL_EN, MUL 6*7 -> done at T+2, result=42.
